// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, counter width and RGB565 palette shared with the picture stage
package vga_pkg;
  localparam int CNT_W = 10;
  localparam int H_SYNC = 96;
  localparam int H_BACK = 40;
  localparam int H_LEFT = 8;
  localparam int H_VALID = 640;
  localparam int H_RIGHT = 8;
  localparam int H_FRONT = 8;
  localparam int H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
  localparam int V_SYNC = 2;
  localparam int V_BACK = 25;
  localparam int V_TOP = 8;
  localparam int V_VALID = 480;
  localparam int V_BOTTOM = 8;
  localparam int V_FRONT = 2;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
  localparam int H_ACT0 = H_SYNC + H_BACK + H_LEFT;
  localparam int V_ACT0 = V_SYNC + V_BACK + V_TOP;
  localparam logic [15:0] RED = 16'hF800;
  localparam logic [15:0] ORANGE = 16'hFC00;
  localparam logic [15:0] YELLOW = 16'hFFE0;
  localparam logic [15:0] GREEN = 16'h07E0;
  localparam logic [15:0] CYAN = 16'h07FF;
  localparam logic [15:0] BLUE = 16'h001F;
  localparam logic [15:0] PURPLE = 16'hF81F;
  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] WHITE = 16'hFFFF;
  localparam logic [15:0] GRAY = 16'hD69A;
endpackage

// File: rtl/vga_timing_ctrl_if.sv
// vga_timing_ctrl_if: picture-side bus; master is the timing controller (coords/sync/rgb out, pix_data in)
interface vga_timing_ctrl_if;
  logic [15:0] pix_data;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic hsync;
  logic vsync;
  logic rgb_valid;
  logic [15:0] rgb;
  logic frame_start;
  logic [7:0] frame_cnt;
  modport master (
    input pix_data,
    output pix_x, pix_y, hsync, vsync, rgb_valid, rgb, frame_start, frame_cnt
  );
  modport slave (
    output pix_data,
    input pix_x, pix_y, hsync, vsync, rgb_valid, rgb, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_wrap_counter.sv
// vga_wrap_counter: modulo-MOD up counter with enable, sync reset rst and combinational wrap flag
module vga_wrap_counter import vga_pkg::*; #(
  parameter int MOD = 800
) (
  input logic clk,
  input logic rst,
  input logic en,
  output logic [CNT_W-1:0] cnt,
  output logic wrap
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MOD - 1);
  assign wrap = en && cnt == LAST;
  always_ff @(posedge clk) cnt <= rst ? '0 : wrap ? '0 : cnt + CNT_W'(en);
endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: raster timing; ports vga_clk, sys_rst and the vga master bus (pix_data in; coords, syncs, rgb, frame pulse/count out)
module vga_timing_ctrl #(
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BACK = vga_pkg::H_BACK,
  parameter int H_LEFT = vga_pkg::H_LEFT,
  parameter int H_VALID = vga_pkg::H_VALID,
  parameter int H_RIGHT = vga_pkg::H_RIGHT,
  parameter int H_FRONT = vga_pkg::H_FRONT,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BACK = vga_pkg::V_BACK,
  parameter int V_TOP = vga_pkg::V_TOP,
  parameter int V_VALID = vga_pkg::V_VALID,
  parameter int V_BOTTOM = vga_pkg::V_BOTTOM,
  parameter int V_FRONT = vga_pkg::V_FRONT
) (
  input logic vga_clk,
  input logic sys_rst,
  vga_timing_ctrl_if.master vga
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
  localparam logic [9:0] HS = 10'(H_SYNC);
  localparam logic [9:0] VS = 10'(V_SYNC);
  localparam logic [9:0] H_ACT0 = 10'(H_SYNC + H_BACK + H_LEFT);
  localparam logic [9:0] H_ACT1 = 10'(H_SYNC + H_BACK + H_LEFT + H_VALID);
  localparam logic [9:0] H_REQ0 = H_ACT0 - 10'd1;
  localparam logic [9:0] H_REQ1 = H_ACT1 - 10'd1;
  localparam logic [9:0] V_ACT0 = 10'(V_SYNC + V_BACK + V_TOP);
  localparam logic [9:0] V_ACT1 = 10'(V_SYNC + V_BACK + V_TOP + V_VALID);
  logic [9:0] h_cnt, v_cnt;
  logic h_wrap, v_wrap, v_act, pix_req, frame_start;
  logic [7:0] frame_cnt;
  vga_wrap_counter #(.MOD(H_TOTAL)) u_h (
    .clk(vga_clk), .rst(sys_rst), .en(1'b1), .cnt(h_cnt), .wrap(h_wrap)
  );
  vga_wrap_counter #(.MOD(V_TOTAL)) u_v (
    .clk(vga_clk), .rst(sys_rst), .en(h_wrap), .cnt(v_cnt), .wrap(v_wrap)
  );
  assign v_act = v_cnt >= V_ACT0 && v_cnt < V_ACT1;
  assign pix_req = h_cnt >= H_REQ0 && h_cnt < H_REQ1 && v_act;
  assign vga.hsync = h_cnt < HS;
  assign vga.vsync = v_cnt < VS;
  assign vga.rgb_valid = h_cnt >= H_ACT0 && h_cnt < H_ACT1 && v_act;
  assign vga.pix_x = pix_req ? h_cnt - H_REQ0 : 10'h3FF;
  assign vga.pix_y = pix_req ? v_cnt - V_ACT0 : 10'h3FF;
  assign vga.rgb = vga.rgb_valid ? vga.pix_data : 16'h0000;
  assign vga.frame_start = frame_start;
  assign vga.frame_cnt = frame_cnt;
  always_ff @(posedge vga_clk) begin
    frame_start <= sys_rst ? 1'b0 : v_wrap;
    frame_cnt <= sys_rst ? 8'd0 : frame_cnt + 8'(v_wrap);
  end
endmodule
